// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: hazard controller FSM states and latch indices.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } hazard_state_t;

    // Pipeline latch positions inside the flush/freeze vectors.
    localparam int LATCH_FT  = 0;  // IF/ID
    localparam int LATCH_DC  = 1;  // ID/EX
    localparam int LATCH_EX  = 2;  // EX/MEM
    localparam int LATCH_MEM = 3;  // MEM/WB

endpackage

// File: rtl/hazard_ctrl_perf_cnt.sv
// Saturating event counter used for the hazard performance statistics.
module hazard_perf_cnt #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    // Increment on enable, sticking at all ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (en && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stateful hazard controller: per-latch flush/freeze plus PC freeze for the
// in-order pipeline. Define HAZARD_PERF_EN to add the stall_cycles and
// flush_events statistics counters.
module hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int N_STAGES = 4,
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                ihit,
    input  logic                dhit,
    input  logic                dmem_req,
    input  logic                ld_dc,
    input  logic [REG_W-1:0]    ld_dst_dc,
    input  logic [REG_W-1:0]    rs_ft,
    input  logic [REG_W-1:0]    rt_ft,
    input  logic                uses_rt_ft,
    input  logic                mispredict,
    input  logic                jump_dc,
    input  logic                halt_ex,
    output logic                pc_freeze,
    output logic [N_STAGES-1:0] flush,
    output logic [N_STAGES-1:0] freeze,
    output logic                halted
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]         stall_cycles,
    output logic [31:0]         flush_events
`endif
);

    // Drain counter only ever holds values up to N_STAGES-2.
    localparam int DCNT_W = $clog2(N_STAGES);

    hazard_state_t     state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;

    logic mem_wait;
    logic load_use;

    assign mem_wait = dmem_req && !dhit;
    assign load_use = ld_dc && (ld_dst_dc != '0) &&
                      ((ld_dst_dc == rs_ft) || (uses_rt_ft && (ld_dst_dc == rt_ft)));

    // Prioritised hazard resolution: outputs and next state from state + inputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dcnt_d    = dcnt_q;
        flush     = '0;
        freeze    = '0;
        pc_freeze = 1'b0;
        halted    = 1'b0;

        if (mem_wait) begin
            // Whole pipe waits on data memory; all state holds.
            freeze    = '1;
            pc_freeze = 1'b1;
        end else if (state_q == HALTED) begin
            freeze    = '1;
            pc_freeze = 1'b1;
            halted    = 1'b1;
        end else if (state_q == DRAIN) begin
            pc_freeze        = 1'b1;
            flush[LATCH_FT]  = 1'b1;
            flush[LATCH_DC]  = 1'b1;
            dcnt_d           = dcnt_q - DCNT_W'(1);
            if (dcnt_q <= DCNT_W'(1)) begin
                state_d = HALTED;
            end
        end else begin
            // RUN or LDSTALL. A halt in EX masks a same-cycle mispredict.
            if (mispredict && !halt_ex) begin
                flush[LATCH_FT] = 1'b1;
                flush[LATCH_DC] = 1'b1;
                state_d         = RUN;
                cnt_d           = '0;
            end else if ((state_q == LDSTALL) || load_use) begin
                // Hold the consumer in IF/ID and feed a bubble into ID/EX.
                pc_freeze        = 1'b1;
                freeze[LATCH_FT] = 1'b1;
                flush[LATCH_DC]  = 1'b1;
                if (state_q == LDSTALL) begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end
                end else if (LOAD_LAT > 1) begin
                    state_d = LDSTALL;
                    cnt_d   = 3'(LOAD_LAT - 1);
                end
            end else if (jump_dc) begin
                flush[LATCH_FT] = 1'b1;
            end else if (!ihit) begin
                pc_freeze       = 1'b1;
                flush[LATCH_FT] = 1'b1;
            end

            if (halt_ex) begin
                state_d = DRAIN;
                dcnt_d  = DCNT_W'(N_STAGES - 2);
                cnt_d   = '0;
            end
        end

        // Reset window: clear every latch, nothing frozen.
        if (!nRST) begin
            flush     = '1;
            freeze    = '0;
            pc_freeze = 1'b0;
            halted    = 1'b0;
        end
    end

    // FSM and counter registers.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= RUN;
            cnt_q   <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic stall_en;
    logic flush_en;

    // Stalls count any frozen-PC cycle except the terminal halted state;
    // flush events are cycles where the mispredict or jump branch won.
    assign stall_en = pc_freeze && (state_q != HALTED);
    assign flush_en = nRST && !mem_wait &&
                      ((state_q == RUN) || (state_q == LDSTALL)) && !halt_ex &&
                      (mispredict ||
                       (jump_dc && (state_q != LDSTALL) && !load_use));

    hazard_perf_cnt #(.W(32)) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .en    (stall_en),
        .count (stall_cycles)
    );

    hazard_perf_cnt #(.W(32)) u_flush_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .en    (flush_en),
        .count (flush_events)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl (N_STAGES=4, LOAD_LAT=2).
module tb_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       ihit, dhit, dmem_req, ld_dc, uses_rt_ft, mispredict, jump_dc, halt_ex;
    logic [4:0] ld_dst_dc, rs_ft, rt_ft;
    logic       pc_freeze, halted;
    logic [3:0] flush, freeze;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_events;
    logic        sat_nrst, sat_en;
    logic [3:0]  sat_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    hazard_ctrl #(.N_STAGES(4), .REG_W(5), .LOAD_LAT(2)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .ihit       (ihit),
        .dhit       (dhit),
        .dmem_req   (dmem_req),
        .ld_dc      (ld_dc),
        .ld_dst_dc  (ld_dst_dc),
        .rs_ft      (rs_ft),
        .rt_ft      (rt_ft),
        .uses_rt_ft (uses_rt_ft),
        .mispredict (mispredict),
        .jump_dc    (jump_dc),
        .halt_ex    (halt_ex),
        .pc_freeze  (pc_freeze),
        .flush      (flush),
        .freeze     (freeze),
        .halted     (halted)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
`endif
    );

`ifdef HAZARD_PERF_EN
    hazard_perf_cnt #(.W(4)) u_sat (
        .CLK   (CLK),
        .nRST  (sat_nrst),
        .en    (sat_en),
        .count (sat_count)
    );
`endif

    typedef struct {
        string      name;
        logic       ihit, dhit, dmem_req, ld_dc;
        logic [4:0] ld_dst, rs, rt;
        logic       uses_rt, mis, jmp, halt;
        logic       pcf;
        logic [3:0] fl, fz;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end else begin
            $display("ok   %s value=%h", name, got);
        end
    endtask

    task automatic set_idle();
        ihit = 1'b1; dhit = 1'b0; dmem_req = 1'b0; ld_dc = 1'b0;
        ld_dst_dc = 5'd0; rs_ft = 5'd0; rt_ft = 5'd0; uses_rt_ft = 1'b0;
        mispredict = 1'b0; jump_dc = 1'b0; halt_ex = 1'b0;
    endtask

    task automatic set_load_use();
        ld_dc = 1'b1; ld_dst_dc = 5'd8; rs_ft = 5'd8; rt_ft = 5'd3;
    endtask

    // Sample outputs on the falling edge, then advance past the next rising edge.
    task automatic cyc(input string name, input logic pcf, input logic hl,
                       input logic [3:0] fl, input logic [3:0] fz);
        @(negedge CLK);
        check(name, {22'd0, pc_freeze, halted, flush, freeze}, {22'd0, pcf, hl, fl, fz});
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        set_idle();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    initial begin
        //          name          ihit  dhit  dmreq ld_dc ld_dst rs     rt     usert mis   jmp   halt  pcf   flush    freeze
        vecs[0]  = '{"idle",      1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
        vecs[1]  = '{"memwait",   1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1111};
        vecs[2]  = '{"dmem_hit",  1'b1, 1'b1, 1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
        vecs[3]  = '{"ihit_low",  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 4'b0000};
        vecs[4]  = '{"jump",      1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000};
        vecs[5]  = '{"jump_nohit",1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0000};
        vecs[6]  = '{"mispredict",1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011, 4'b0000};
        vecs[7]  = '{"lu_rs",     1'b1, 1'b0, 1'b0, 1'b1, 5'd8,  5'd8,  5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 4'b0001};
        vecs[8]  = '{"lu_rt",     1'b1, 1'b0, 1'b0, 1'b1, 5'd5,  5'd3,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 4'b0001};
        vecs[9]  = '{"rt_unused", 1'b1, 1'b0, 1'b0, 1'b1, 5'd5,  5'd3,  5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
        vecs[10] = '{"dst_zero",  1'b1, 1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
        vecs[11] = '{"lu_mispr",  1'b1, 1'b0, 1'b0, 1'b1, 5'd8,  5'd8,  5'd3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011, 4'b0000};
        vecs[12] = '{"lu_memwait",1'b1, 1'b0, 1'b1, 1'b1, 5'd8,  5'd8,  5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1111};
        vecs[13] = '{"mispr_jump",1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0011, 4'b0000};
        vecs[14] = '{"lu_nohit",  1'b0, 1'b0, 1'b0, 1'b1, 5'd8,  5'd8,  5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 4'b0001};
        vecs[15] = '{"no_load",   1'b1, 1'b0, 1'b0, 1'b0, 5'd8,  5'd8,  5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000};
        vecs[16] = '{"lu_jump",   1'b1, 1'b0, 1'b0, 1'b1, 5'd8,  5'd8,  5'd3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0010, 4'b0001};

`ifdef HAZARD_PERF_EN
        sat_nrst = 1'b0;
        sat_en   = 1'b1;
`endif
        // Reset window outputs.
        nRST = 1'b0;
        set_idle();
        cyc("reset_window", 1'b0, 1'b0, 4'b1111, 4'b0000);
        nRST = 1'b1;
        cyc("after_reset", 1'b0, 1'b0, 4'b0000, 4'b0000);

        // Single-cycle vectors, each from a freshly reset RUN state.
        for (int i = 0; i < 17; i++) begin
            do_reset();
            ihit = vecs[i].ihit; dhit = vecs[i].dhit; dmem_req = vecs[i].dmem_req;
            ld_dc = vecs[i].ld_dc; ld_dst_dc = vecs[i].ld_dst; rs_ft = vecs[i].rs;
            rt_ft = vecs[i].rt; uses_rt_ft = vecs[i].uses_rt; mispredict = vecs[i].mis;
            jump_dc = vecs[i].jmp; halt_ex = vecs[i].halt;
            cyc(vecs[i].name, vecs[i].pcf, 1'b0, vecs[i].fl, vecs[i].fz);
        end

        // Load-use with LOAD_LAT=2: exactly two stall cycles then RUN.
        do_reset();
        set_load_use();
        cyc("ld2_cycle0", 1'b1, 1'b0, 4'b0010, 4'b0001);
        set_idle();
        cyc("ld2_cycle1", 1'b1, 1'b0, 4'b0010, 4'b0001);
        cyc("ld2_run", 1'b0, 1'b0, 4'b0000, 4'b0000);

        // Memory wait inside LDSTALL holds the count; stall resumes afterwards.
        do_reset();
        set_load_use();
        cyc("ldmw_hazard", 1'b1, 1'b0, 4'b0010, 4'b0001);
        set_idle();
        dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) cyc($sformatf("ldmw_wait%0d", i), 1'b1, 1'b0, 4'b0000, 4'b1111);
        dmem_req = 1'b0;
        cyc("ldmw_resume", 1'b1, 1'b0, 4'b0010, 4'b0001);
        cyc("ldmw_run", 1'b0, 1'b0, 4'b0000, 4'b0000);

        // Mispredict aborts a load-use stall: next cycle is plain RUN.
        do_reset();
        set_load_use();
        mispredict = 1'b1;
        cyc("mis_lu", 1'b0, 1'b0, 4'b0011, 4'b0000);
        set_idle();
        cyc("mis_lu_run", 1'b0, 1'b0, 4'b0000, 4'b0000);

        // Halt drain: two DRAIN cycles, then HALTED until reset.
        do_reset();
        halt_ex = 1'b1;
        cyc("halt_run", 1'b0, 1'b0, 4'b0000, 4'b0000);
        halt_ex = 1'b0;
        cyc("drain0", 1'b1, 1'b0, 4'b0011, 4'b0000);
        cyc("drain1", 1'b1, 1'b0, 4'b0011, 4'b0000);
        cyc("halted0", 1'b1, 1'b1, 4'b0000, 4'b1111);
        mispredict = 1'b1; jump_dc = 1'b1;
        cyc("halted_sticky", 1'b1, 1'b1, 4'b0000, 4'b1111);
        set_idle();
        nRST = 1'b0;
        cyc("halt_reset", 1'b0, 1'b0, 4'b1111, 4'b0000);
        nRST = 1'b1;
        cyc("halt_exit_run", 1'b0, 1'b0, 4'b0000, 4'b0000);

        // Halt beats same-cycle mispredict; memory wait pauses the drain count.
        do_reset();
        halt_ex = 1'b1; mispredict = 1'b1;
        cyc("halt_mis", 1'b0, 1'b0, 4'b0000, 4'b0000);
        set_idle();
        cyc("drainb0", 1'b1, 1'b0, 4'b0011, 4'b0000);
        dmem_req = 1'b1;
        cyc("drainb_wait", 1'b1, 1'b0, 4'b0000, 4'b1111);
        dmem_req = 1'b0;
        cyc("drainb1", 1'b1, 1'b0, 4'b0011, 4'b0000);
        cyc("haltedb", 1'b1, 1'b1, 4'b0000, 4'b1111);

`ifdef HAZARD_PERF_EN
        // Three stall cycles and two mispredicts.
        do_reset();
        ihit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
        end
        ihit = 1'b1;
        mispredict = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK);
            #1;
        end
        set_idle();
        @(negedge CLK);
        check("perf_stall_cycles", stall_cycles, 32'd3);
        check("perf_flush_events", flush_events, 32'd2);

        // Saturation on a narrow counter instance.
        @(posedge CLK);
        #1;
        sat_nrst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            #1;
        end
        @(negedge CLK);
        check("perf_saturate", {28'd0, sat_count}, 32'h0000000f);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
